// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
//
// Power-up and boot controller for the bubble memory cartridge emulator.
// Waits for a clean, debounced power_good, latches the image DIP switch once
// per power cycle, asks the SPI loader for that image, times the heater
// warm-up and finally releases the bubble interface. Any power loss drops the
// sequence back to OFF; a flash error or load timeout parks it in ERROR until
// power loss or reset.
//
// Ports:
//   master_clock_i            48 MHz master clock
//   reset_i                   asynchronous, active-high reset
//   power_good_i              board power status (asynchronous, synchronised here)
//   image_dip_switch_i [2:0]  image select switches, sampled in LATCH only
//   spi_load_done_i           one-cycle pulse from SPILoader: image loaded
//   flash_error_i             level from SPILoader: flash read failed
//   image_number_o     [2:0]  latched image index for SPILoader
//   spi_load_start_o          one-cycle load request pulse
//   bubble_interface_enable_o active low; 1 = interface held disabled
//   temperature_low_o         1 = heater warming / not ready, 0 = ready
//   boot_error_o              sticky error flag until power loss or reset
//   boot_state_o       [2:0]  current state encoding, for debug
// -----------------------------------------------------------------------------
module boot_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES     = 48000,
  parameter int unsigned LOAD_TIMEOUT_CYCLES = 4800000,
  parameter int unsigned WARMUP_CYCLES       = 96000,
  parameter int unsigned CNT_W               = 24
) (
  input  logic       master_clock_i,
  input  logic       reset_i,
  input  logic       power_good_i,
  input  logic [2:0] image_dip_switch_i,
  input  logic       spi_load_done_i,
  input  logic       flash_error_i,
  output logic [2:0] image_number_o,
  output logic       spi_load_start_o,
  output logic       bubble_interface_enable_o,
  output logic       temperature_low_o,
  output logic       boot_error_o,
  output logic [2:0] boot_state_o
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_LATCH     = 3'd2,
    ST_LOAD      = 3'd3,
    ST_LOAD_WAIT = 3'd4,
    ST_WARMUP    = 3'd5,
    ST_READY     = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  // Reload values are one less than the cycle count so that a state which
  // leaves at counter==0 lasts exactly the parameter number of cycles.
  localparam logic [CNT_W-1:0] DEBOUNCE_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_RELOAD  = CNT_W'(LOAD_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARMUP_RELOAD   = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

  // power_good synchroniser
  logic pg_meta_q;
  logic pg_s_q;

  // FSM state and shared down-counter
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered outputs
  logic [2:0] image_number_q, image_number_d;
  logic       spi_load_start_q, spi_load_start_d;
  logic       bie_q, bie_d;
  logic       temp_low_q, temp_low_d;
  logic       boot_error_q, boot_error_d;

  always_ff @(posedge master_clock_i or posedge reset_i) begin
    if (reset_i) begin
      pg_meta_q <= 1'b0;
      pg_s_q    <= 1'b0;
    end else begin
      pg_meta_q <= power_good_i;
      pg_s_q    <= pg_meta_q;
    end
  end

  always_ff @(posedge master_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= ST_OFF;
      cnt_q            <= '0;
      image_number_q   <= 3'd0;
      spi_load_start_q <= 1'b0;
      bie_q            <= 1'b1;
      temp_low_q       <= 1'b1;
      boot_error_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      image_number_q   <= image_number_d;
      spi_load_start_q <= spi_load_start_d;
      bie_q            <= bie_d;
      temp_low_q       <= temp_low_d;
      boot_error_q     <= boot_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    image_number_d = image_number_q;

    // Power loss overrides every state's own transition, including a
    // pending image latch, so a half-finished power cycle never updates
    // image_number.
    if ((state_q != ST_OFF) && !pg_s_q) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pg_s_q) begin
            cnt_d   = DEBOUNCE_RELOAD;
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (cnt_q == '0) state_d = ST_LATCH;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        ST_LATCH: begin
          image_number_d = image_dip_switch_i;
          state_d        = ST_LOAD;
        end
        ST_LOAD: begin
          cnt_d   = TIMEOUT_RELOAD;
          state_d = ST_LOAD_WAIT;
        end
        ST_LOAD_WAIT: begin
          // Error wins over a simultaneous done pulse.
          if (flash_error_i) begin
            state_d = ST_ERROR;
          end else if (spi_load_done_i) begin
            cnt_d   = WARMUP_RELOAD;
            state_d = ST_WARMUP;
          end else if (cnt_q == '0) begin
            state_d = ST_ERROR;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_WARMUP: begin
          if (cnt_q == '0) state_d = ST_READY;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        ST_READY: state_d = ST_READY;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_OFF;
      endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so each output changes on the very first cycle of the state it belongs
    // to while remaining glitch-free flop outputs.
    spi_load_start_d = (state_d == ST_LOAD);
    bie_d            = (state_d != ST_READY);
    temp_low_d       = (state_d != ST_READY);
    boot_error_d     = (state_d == ST_ERROR);
  end

  assign image_number_o            = image_number_q;
  assign spi_load_start_o          = spi_load_start_q;
  assign bubble_interface_enable_o = bie_q;
  assign temperature_low_o         = temp_low_q;
  assign boot_error_o              = boot_error_q;
  assign boot_state_o              = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_boot_sequencer
//
// Directed scenarios followed by randomized power/load activity. A behavioural
// model tracks the boot phase and how many cycles have elapsed in it, and
// every cycle all DUT outputs are compared with what the model predicts.
// -----------------------------------------------------------------------------
module tb_boot_sequencer;

  localparam int DEB = 8;
  localparam int TO  = 20;
  localparam int WU  = 10;

  localparam int S_OFF   = 0;
  localparam int S_DEB   = 1;
  localparam int S_LATCH = 2;
  localparam int S_LOAD  = 3;
  localparam int S_WAIT  = 4;
  localparam int S_WARM  = 5;
  localparam int S_READY = 6;
  localparam int S_ERR   = 7;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       pg   = 1'b0;
  logic [2:0] dip  = 3'd0;
  logic       done = 1'b0;
  logic       ferr = 1'b0;

  logic [2:0] image_number_o;
  logic       spi_load_start_o;
  logic       bubble_interface_enable_o;
  logic       temperature_low_o;
  logic       boot_error_o;
  logic [2:0] boot_state_o;

  always #5 clk = ~clk;

  boot_sequencer #(
    .DEBOUNCE_CYCLES    (DEB),
    .LOAD_TIMEOUT_CYCLES(TO),
    .WARMUP_CYCLES      (WU),
    .CNT_W              (24)
  ) dut (
    .master_clock_i           (clk),
    .reset_i                  (rst),
    .power_good_i             (pg),
    .image_dip_switch_i       (dip),
    .spi_load_done_i          (done),
    .flash_error_i            (ferr),
    .image_number_o           (image_number_o),
    .spi_load_start_o         (spi_load_start_o),
    .bubble_interface_enable_o(bubble_interface_enable_o),
    .temperature_low_o        (temperature_low_o),
    .boot_error_o             (boot_error_o),
    .boot_state_o             (boot_state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int starts_seen = 0;

  // Reference model: boot phase, cycles already spent in it, latched image
  // and the two-stage power_good delay line.
  int         m_st;
  int         m_age;
  logic [2:0] m_img;
  logic       m_p1, m_p2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_st  = S_OFF;
    m_age = 0;
    m_img = 3'd0;
    m_p1  = 1'b0;
    m_p2  = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs held across it.
  task automatic model_step();
    logic pgs;
    int   nxt;
    pgs  = m_p2;
    m_p2 = m_p1;
    m_p1 = pg;
    nxt  = m_st;
    if (m_st != S_OFF && !pgs) begin
      nxt = S_OFF;
    end else begin
      case (m_st)
        S_OFF:   if (pgs) nxt = S_DEB;
        S_DEB:   if (m_age + 1 == DEB) nxt = S_LATCH;
        S_LATCH: begin m_img = dip; nxt = S_LOAD; end
        S_LOAD:  nxt = S_WAIT;
        S_WAIT: begin
          if (ferr)                  nxt = S_ERR;
          else if (done)             nxt = S_WARM;
          else if (m_age + 1 == TO)  nxt = S_ERR;
        end
        S_WARM:  if (m_age + 1 == WU) nxt = S_READY;
        default: ;
      endcase
    end
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  task automatic check_outputs();
    check_eq("state",      boot_state_o,              m_st);
    check_eq("image",      image_number_o,            m_img);
    check_eq("start",      spi_load_start_o,          (m_st == S_LOAD));
    check_eq("bie",        bubble_interface_enable_o, (m_st != S_READY));
    check_eq("temp_low",   temperature_low_o,         (m_st != S_READY));
    check_eq("boot_error", boot_error_o,              (m_st == S_ERR));
  endtask

  // Advance one clock; inputs are changed only between calls (after the
  // falling edge), outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    cyc++;
    @(negedge clk);
    if (spi_load_start_o) starts_seen++;
    check_outputs();
  endtask

  task automatic wait_model(input int target, input int budget);
    int k;
    k = 0;
    while (m_st != target && k < budget) begin
      tick();
      k++;
    end
    if (m_st != target) check_eq("wait_model_expired", m_st, target);
  endtask

  task automatic wait_dut(input string tag, input int target, input int budget, output int k);
    k = 0;
    while (boot_state_o != 3'(target) && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, boot_state_o, target);
  endtask

  task automatic power_off(input int n);
    pg = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int k;
    int seen_off;

    model_reset();
    repeat (2) tick();
    check_eq("rst_state", boot_state_o, 0);
    check_eq("rst_bie",   bubble_interface_enable_o, 1);
    check_eq("rst_tl",    temperature_low_o, 1);
    check_eq("rst_err",   boot_error_o, 0);
    check_eq("rst_start", spi_load_start_o, 0);
    check_eq("rst_img",   image_number_o, 0);
    rst = 1'b0;
    tick();

    // ---------------- nominal boot ----------------
    dip = 3'b101;
    starts_seen = 0;
    pg = 1'b1;
    wait_model(S_LOAD, 40);
    repeat (5) tick();
    done = 1'b1;
    k = 0;
    while (bubble_interface_enable_o !== 1'b0 && k < 40) begin
      tick();
      k++;
      if (k == 1) done = 1'b0;
    end
    done = 1'b0;
    // done is sampled on the first edge; warm-up then lasts WU cycles
    check_eq("nom_ready_latency", k, WU + 1);
    check_eq("nom_tl_with_bie", temperature_low_o, 0);
    check_eq("nom_img", image_number_o, 3'd5);
    check_eq("nom_one_start", starts_seen, 1);
    repeat (5) tick();
    check_eq("nom_hold_ready", boot_state_o, S_READY);

    // ---------------- power loss in READY ----------------
    pg = 1'b0;
    k = 0;
    while (bubble_interface_enable_o !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check_eq("pl_latency", k, 3);
    check_eq("pl_tl", temperature_low_o, 1);
    dip = 3'b010;
    repeat (5) tick();
    check_eq("pl_img_hold", image_number_o, 3'd5);
    pg = 1'b1;
    wait_model(S_LOAD, 40);
    check_eq("pl_img_new", image_number_o, 3'd2);
    power_off(5);

    // ---------------- glitchy power ----------------
    starts_seen = 0;
    seen_off = 0;
    pg = 1'b1;
    repeat (5) tick();
    pg = 1'b0;
    tick();
    pg = 1'b1;
    k = 0;
    while (boot_state_o != 3'(S_LATCH) && k < 40) begin
      tick();
      k++;
      if (k > 1 && boot_state_o == 3'(S_OFF)) seen_off = 1;
    end
    check_eq("glitch_back_to_off", seen_off, 1);
    // two synchroniser edges, one OFF->DEBOUNCE edge, then the full debounce
    check_eq("glitch_latch_latency", k, DEB + 3);
    check_eq("glitch_no_start", starts_seen, 0);

    // ---------------- flash error with simultaneous done ----------------
    wait_model(S_WAIT, 10);
    repeat (2) tick();
    ferr = 1'b1;
    done = 1'b1;
    tick();
    ferr = 1'b0;
    done = 1'b0;
    check_eq("fe_state", boot_state_o, S_ERR);
    check_eq("fe_err", boot_error_o, 1);
    check_eq("fe_bie", bubble_interface_enable_o, 1);
    repeat (4) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (4) tick();
    check_eq("fe_sticky", boot_state_o, S_ERR);
    power_off(3);
    check_eq("fe_off_state", boot_state_o, S_OFF);
    check_eq("fe_off_err", boot_error_o, 0);
    tick();

    // ---------------- load timeout ----------------
    pg = 1'b1;
    wait_model(S_LOAD, 40);
    wait_dut("to_reach_error", S_ERR, 60, k);
    check_eq("to_latency", k, TO + 1);
    check_eq("to_err", boot_error_o, 1);
    power_off(5);

    // ---------------- async reset mid-WARMUP ----------------
    pg = 1'b1;
    wait_model(S_WAIT, 40);
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_state", boot_state_o, 0);
    check_eq("arst_bie",   bubble_interface_enable_o, 1);
    check_eq("arst_tl",    temperature_low_o, 1);
    check_eq("arst_err",   boot_error_o, 0);
    check_eq("arst_start", spi_load_start_o, 0);
    check_eq("arst_img",   image_number_o, 0);
    model_reset();
    repeat (2) tick();
    #2 rst = 1'b0;
    wait_model(S_WAIT, 40);
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_dut("arst_reboot_ready", S_READY, 40, k);

    // ---------------- randomized activity ----------------
    for (int ep = 0; ep < 30; ep++) begin
      dip = 3'($urandom);
      power_off($urandom_range(3, 6));
      pg = 1'b1;
      for (int i = 0; i < int'($urandom_range(30, 90)); i++) begin
        done = ($urandom_range(0, 9) == 0);
        ferr = ($urandom_range(0, 39) == 0);
        pg   = ($urandom_range(0, 59) != 0);
        tick();
      end
      done = 1'b0;
      ferr = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Power-up and boot controller for the bubble memory cartridge emulator.
- Debounces power_good from the BUBBLE SYSTEM board and latches the image DIP switch once per power cycle.
- Commands the SPI loader to fetch the selected image, times the heater/warm-up interval, then releases the bubble interface.
- Sits between the board power signals, SPILoader and BubbleInterface; it sequences all three.

Parameters:
- DEBOUNCE_CYCLES, 48000, consecutive master_clock cycles power_good must stay high before boot starts (1 ms at 48 MHz).
- LOAD_TIMEOUT_CYCLES, 4800000, maximum cycles to wait for spi_load_done after the start pulse (100 ms).
- WARMUP_CYCLES, 96000, cycles temperature_low stays asserted after a successful load (2 ms).
- CNT_W, 24, width of the shared down-counter; must hold the largest parameter value.

Ports:
- master_clock  input  1  48 MHz master clock.
- reset  input  1  asynchronous, active-high reset.
- power_good  input  1  board power status; asynchronous, double-flopped internally.
- image_dip_switch  input  3  image select switches; static, sampled only in LATCH.
- spi_load_done  input  1  one-cycle pulse from SPILoader: image loaded.
- flash_error  input  1  level from SPILoader: flash read failed.
- image_number  output  3  latched image index for SPILoader.
- spi_load_start  output  1  one-cycle load request pulse.
- bubble_interface_enable  output  1  active low; 1 = interface held disabled.
- temperature_low  output  1  READY emulation; 1 = heater warming, not ready; 0 = ready.
- boot_error  output  1  sticky error flag until power loss or reset.
- boot_state  output  3  current state encoding, for debug.

Behaviour:
- Reset values: image_number=0, spi_load_start=0, bubble_interface_enable=1, temperature_low=1, boot_error=0, state=OFF (0), counter=0.
- power_good passes through a 2-flop synchroniser before use. pg_s denotes the synchronised value; the input-to-FSM latency is 2 cycles.
- All outputs are registered.
- State encoding: OFF=0, DEBOUNCE=1, LATCH=2, LOAD=3, LOAD_WAIT=4, WARMUP=5, READY=6, ERROR=7.
- OFF: if pg_s=1, load counter with DEBOUNCE_CYCLES-1 and go to DEBOUNCE.
- DEBOUNCE: if pg_s=0, return to OFF. Otherwise decrement; at counter=0, go to LATCH.
- LATCH: image_number <= image_dip_switch, go to LOAD. This is the only state that writes image_number; it holds through the power cycle.
- LOAD: assert spi_load_start for exactly this one cycle, load counter with LOAD_TIMEOUT_CYCLES-1, go to LOAD_WAIT.
- LOAD_WAIT, evaluated in priority order:
  - flash_error=1 goes to ERROR.
  - spi_load_done=1 loads counter with WARMUP_CYCLES-1 and goes to WARMUP.
  - counter=0 (timeout) goes to ERROR.
  - otherwise decrement.
  - done and error in the same cycle goes to ERROR.
- WARMUP: temperature_low=1. Decrement; at counter=0, go to READY.
- READY: temperature_low=0 and bubble_interface_enable=0, both effective on the first cycle the state is READY. Hold while pg_s=1.
- ERROR: boot_error=1, temperature_low=1, bubble_interface_enable=1. Only power loss or reset exits.
- Power loss: pg_s=0 in any state other than OFF goes to OFF on the next edge.
  - On entry to OFF: bubble_interface_enable=1, temperature_low=1, boot_error=0, spi_load_start=0.
  - image_number keeps its last value until the next LATCH.
- spi_load_done pulses outside LOAD_WAIT are ignored.
- reset mid-operation forces all reset values immediately, asynchronously.
- Counter behaviour:
  - The counter never underflows; a zero-valued parameter is illegal.
  - Any reload value is the parameter minus one.
  - Each state therefore lasts exactly its parameter count of cycles.
- boot_state mirrors the state register.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=8, LOAD_TIMEOUT_CYCLES=20, WARMUP_CYCLES=10.)
- Nominal boot:
  - Stimulus: dip=3'b101, power_good rises, then spi_load_done is pulsed 5 cycles after spi_load_start.
  - Required: image_number=5; exactly one spi_load_start pulse; temperature_low and bubble_interface_enable fall together 10 cycles after the done pulse.
- Glitchy power:
  - Stimulus: power_good high 5 cycles, low 1, then high.
  - Required: state returns to OFF; the debounce restarts and LATCH is reached 8 cycles after pg_s is stable.
  - Required: no spi_load_start during the glitch.
- Flash error:
  - Stimulus: flash_error=1 in LOAD_WAIT, also in the same cycle as spi_load_done.
  - Required: boot_error=1, state=7, bubble_interface_enable stays 1.
  - Required: recovery only after power_good low, with boot_error cleared in OFF.
- Load timeout:
  - Stimulus: no spi_load_done.
  - Required: ERROR entered exactly 20 cycles after the spi_load_start pulse.
- Power loss in READY:
  - Stimulus: power_good falls while in READY.
  - Required: bubble_interface_enable=1 and temperature_low=1 within 3 cycles of the power_good fall.
  - Required: dip changed to 3'b010 while OFF is picked up only at the next LATCH.
- Async reset:
  - Stimulus: reset asserted mid-WARMUP, away from any clock edge.
  - Required: all outputs at reset values immediately.
  - Required: after release, a full boot sequence repeats.
